// File: rtl/merger_p_stream.sv
// Two-way streaming merger: sorted runs A and B in, one sorted run out, P records per beat, terminator-delimited runs.
// One registered output stage after a single-cycle 2P bitonic merge; each input has a 2-entry skid buffer, ready whenever an entry is free.
module merger_p_stream #(
  parameter int P          = 8,
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P*DATA_WIDTH-1:0] i_a_data,
  input  logic                    i_a_valid,
  output logic                    o_a_ready,
  input  logic [P*DATA_WIDTH-1:0] i_b_data,
  input  logic                    i_b_valid,
  output logic                    o_b_ready,
  output logic [P*DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [CNT_WIDTH-1:0]    o_runs_done
);
  localparam int BW = P * DATA_WIDTH;
  localparam int IW = (P > 1) ? $clog2(P) : 1;
  localparam int EW = KEY_WIDTH + 2 + IW;
  localparam int N2 = 2 * P;

  typedef enum logic [1:0] {MERGE, DRAIN_A, DRAIN_B, FLUSH} state_t;
  state_t state_q, state_d;

  logic                 live;
  logic [BW-1:0]        in_data [2];
  logic                 in_valid [2];
  logic [BW-1:0]        head [2];
  logic [1:0]           cnt [2];
  logic                 rdy [2];
  logic                 push [2];
  logic                 pop [2];
  logic                 hvld [2];
  logic                 hterm [2];
  logic [KEY_WIDTH-1:0] hkey [2];

  assign in_data[0]  = i_a_data;
  assign in_data[1]  = i_b_data;
  assign in_valid[0] = i_a_valid;
  assign in_valid[1] = i_b_valid;
  assign o_a_ready   = rdy[0];
  assign o_b_ready   = rdy[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      rdy[s]   = live && (cnt[s] != 2'd2);
      push[s]  = in_valid[s] && rdy[s];
      hvld[s]  = (cnt[s] != 2'd0);
      hterm[s] = (head[s][DATA_WIDTH-1:0] == '0);
      hkey[s]  = head[s][KEY_WIDTH-1:0];
    end
  end

  // e0 is always the head entry, so the merge reads a fixed register.
  for (genvar s = 0; s < 2; s++) begin : g_skid
    logic [BW-1:0] e0, e1;
    logic [1:0]    n;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        e0 <= '0;
        e1 <= '0;
        n  <= 2'd0;
      end else begin
        case ({push[s], pop[s]})
          2'b10: begin
            if (n == 2'd0) e0 <= in_data[s];
            else           e1 <= in_data[s];
            n <= n + 2'd1;
          end
          2'b01: begin
            e0 <= e1;
            n  <= n - 2'd1;
          end
          2'b11: begin
            if (n == 2'd1) e0 <= in_data[s];
            else begin
              e0 <= e1;
              e1 <= in_data[s];
            end
          end
          default: ;
        endcase
      end
    end
    assign head[s] = e0;
    assign cnt[s]  = n;
  end

  logic [BW-1:0] held_q;
  logic [P-1:0]  held_src;
  logic          held_vld;
  logic          out_term;
  logic          out_free, step_ok;
  logic          step, sel, flush_held, flush_term;

  assign out_free = !o_valid || i_ready;
  assign step_ok  = !held_vld || out_free;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= MERGE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MERGE: begin
        if (hvld[0] && hterm[0] && hvld[1] && hterm[1]) state_d = FLUSH;
        else if (hvld[0] && hterm[0])                   state_d = DRAIN_B;
        else if (hvld[1] && hterm[1])                   state_d = DRAIN_A;
      end
      DRAIN_A: if (hvld[0] && hterm[0]) state_d = FLUSH;
      DRAIN_B: if (hvld[1] && hterm[1]) state_d = FLUSH;
      FLUSH:   if (out_free && !held_vld) state_d = MERGE;
      default: state_d = MERGE;
    endcase
  end

  always_comb begin
    pop[0] = 1'b0;
    pop[1] = 1'b0;
    step = 1'b0;
    sel = 1'b0;
    flush_held = 1'b0;
    flush_term = 1'b0;
    case (state_q)
      MERGE: begin
        if (hvld[0] && hterm[0]) pop[0] = 1'b1;
        if (hvld[1] && hterm[1]) pop[1] = 1'b1;
        if (hvld[0] && hvld[1] && !hterm[0] && !hterm[1] && step_ok) begin
          step   = 1'b1;
          sel    = (hkey[1] < hkey[0]);
          pop[0] = !sel;
          pop[1] = sel;
        end
      end
      DRAIN_A: begin
        if (hvld[0] && (hterm[0] || step_ok)) pop[0] = 1'b1;
        step = hvld[0] && !hterm[0] && step_ok;
      end
      DRAIN_B: begin
        sel = 1'b1;
        if (hvld[1] && (hterm[1] || step_ok)) pop[1] = 1'b1;
        step = hvld[1] && !hterm[1] && step_ok;
      end
      FLUSH: begin
        flush_held = out_free && held_vld;
        flush_term = out_free && !held_vld;
      end
      default: ;
    endcase
  end

  // Sort key extended with {source, newer, index} makes every key unique and the merge stable.
  logic [BW-1:0]         beat, lo_dat, hi_dat;
  logic [P-1:0]          hi_src;
  logic [DATA_WIDTH-1:0] m_rec [N2];
  logic [EW-1:0]         m_key [N2];
  logic                  m_src [N2];
  logic [DATA_WIDTH-1:0] t_rec;
  logic [EW-1:0]         t_key;
  logic                  t_src;

  always_comb begin
    beat   = sel ? head[1] : head[0];
    t_rec  = '0;
    t_key  = '0;
    t_src  = 1'b0;
    lo_dat = '0;
    hi_dat = '0;
    hi_src = '0;
    for (int i = 0; i < P; i++) begin
      m_rec[i]        = held_q[i*DATA_WIDTH +: DATA_WIDTH];
      m_src[i]        = held_src[i];
      m_key[i]        = {held_q[i*DATA_WIDTH +: KEY_WIDTH], held_src[i], 1'b0, IW'(i)};
      m_rec[N2-1-i]   = beat[i*DATA_WIDTH +: DATA_WIDTH];
      m_src[N2-1-i]   = sel;
      m_key[N2-1-i]   = {beat[i*DATA_WIDTH +: KEY_WIDTH], sel, 1'b1, IW'(i)};
    end
    for (int d = P; d > 0; d = d / 2) begin
      for (int b = 0; b < N2; b += 2 * d) begin
        for (int j = 0; j < d; j++) begin
          if (m_key[b+j] > m_key[b+j+d]) begin
            t_rec = m_rec[b+j]; m_rec[b+j] = m_rec[b+j+d]; m_rec[b+j+d] = t_rec;
            t_key = m_key[b+j]; m_key[b+j] = m_key[b+j+d]; m_key[b+j+d] = t_key;
            t_src = m_src[b+j]; m_src[b+j] = m_src[b+j+d]; m_src[b+j+d] = t_src;
          end
        end
      end
    end
    for (int i = 0; i < P; i++) begin
      lo_dat[i*DATA_WIDTH +: DATA_WIDTH] = m_rec[i];
      hi_dat[i*DATA_WIDTH +: DATA_WIDTH] = m_rec[P+i];
      hi_src[i]                          = m_src[P+i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      held_q      <= '0;
      held_src    <= '0;
      held_vld    <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      out_term    <= 1'b0;
      o_runs_done <= '0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        if (out_term) o_runs_done <= o_runs_done + CNT_WIDTH'(1);
      end
      if (step) begin
        if (held_vld) begin
          o_data   <= lo_dat;
          o_valid  <= 1'b1;
          out_term <= 1'b0;
          held_q   <= hi_dat;
          held_src <= hi_src;
        end else begin
          held_q   <= beat;
          held_src <= {P{sel}};
          held_vld <= 1'b1;
        end
      end
      if (flush_held) begin
        o_data   <= held_q;
        o_valid  <= 1'b1;
        out_term <= 1'b0;
        held_vld <= 1'b0;
      end
      if (flush_term) begin
        o_data   <= '0;
        o_valid  <= 1'b1;
        out_term <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_merger_p_stream.sv
// Scoreboard bench for merger_p_stream at P=4, 32-bit records, 16-bit keys.
module tb_merger_p_stream;
  localparam int P  = 4;
  localparam int DW = 32;
  localparam int KW = 16;
  localparam int CW = 16;
  localparam int BW = P * DW;
  localparam logic [BW-1:0] TERM = '0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] a_data, b_data, o_data;
  logic          a_valid, b_valid, a_ready, b_ready, o_valid, i_ready;
  logic [CW-1:0] runs_done;

  merger_p_stream #(.P(P), .DATA_WIDTH(DW), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_data(a_data), .i_a_valid(a_valid), .o_a_ready(a_ready),
    .i_b_data(b_data), .i_b_valid(b_valid), .o_b_ready(b_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_runs_done(runs_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  int acc_cnt = 0;
  bit abort = 1'b0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] qa[$];
  logic [BW-1:0] qb[$];

  function automatic logic [BW-1:0] bt(input int r0, input int r1, input int r2, input int r3);
    return {32'(r3), 32'(r2), 32'(r1), 32'(r0)};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  initial begin : drv_a
    bit got;
    a_valid = 1'b0; a_data = '0;
    @(posedge clk); #1;
    forever begin
      if (!abort && qa.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        a_data = qa.pop_front(); a_valid = 1'b1; got = 1'b0;
        while (!got && !abort) begin
          @(negedge clk);
          if (a_ready && !abort) got = 1'b1;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
      end else begin
        a_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
  end

  initial begin : drv_b
    bit got;
    b_valid = 1'b0; b_data = '0;
    @(posedge clk); #1;
    forever begin
      if (!abort && qb.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        b_data = qb.pop_front(); b_valid = 1'b1; got = 1'b0;
        while (!got && !abort) begin
          @(negedge clk);
          if (b_ready && !abort) got = 1'b1;
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
      end else begin
        b_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
  end

  // Monitor: a beat seen valid&ready here transfers on the next rising edge.
  bit            hold_chk = 1'b0;
  logic [BW-1:0] hold_dat;
  logic [BW-1:0] mexp;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", BW'(o_valid), BW'(1));
        chk("hold_data", o_data, hold_dat);
      end
      hold_chk = o_valid && !i_ready;
      hold_dat = o_data;
      if (o_valid && i_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_extra: got beat %h, required no beat", o_data);
        end else begin
          mexp = exp_q.pop_front();
          chk("out_beat", o_data, mexp);
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || qa.size() != 0 || qb.size() != 0) && n < budget) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d beats still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; abort = 1'b1;
    qa.delete(); qb.delete(); exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; abort = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic load_t1();
    exp_q.push_back(bt(1, 2, 3, 4)); exp_q.push_back(bt(5, 6, 7, 8));
    exp_q.push_back(bt(9, 11, 13, 15)); exp_q.push_back(TERM);
    qa.push_back(bt(1, 3, 5, 7)); qa.push_back(bt(9, 11, 13, 15)); qa.push_back(TERM);
    qb.push_back(bt(2, 4, 6, 8)); qb.push_back(TERM);
  endtask

  task automatic load_t3();
    exp_q.push_back(bt(1, 2, 3, 4)); exp_q.push_back(bt(6, 7, 8, 9));
    exp_q.push_back(TERM); exp_q.push_back(TERM);
    qa.push_back(TERM); qa.push_back(TERM);
    qb.push_back(bt(1, 2, 3, 4)); qb.push_back(bt(6, 7, 8, 9));
    qb.push_back(TERM); qb.push_back(TERM);
  endtask

  task automatic load_random_run();
    int ka[$], kb[$], km[$];
    int na, nb, cur, i, j;
    na = $urandom_range(0, 8);
    nb = $urandom_range(0, 8);
    cur = $urandom_range(1, 20);
    for (int k = 0; k < na * P; k++) begin cur += $urandom_range(0, 5); ka.push_back(cur); end
    cur = $urandom_range(1, 20);
    for (int k = 0; k < nb * P; k++) begin cur += $urandom_range(0, 5); kb.push_back(cur); end
    i = 0; j = 0;
    while (i < ka.size() || j < kb.size()) begin
      if (j >= kb.size() || (i < ka.size() && ka[i] <= kb[j])) begin km.push_back(ka[i]); i++; end
      else begin km.push_back(kb[j]); j++; end
    end
    for (int k = 0; k < km.size(); k += P) exp_q.push_back(bt(km[k], km[k+1], km[k+2], km[k+3]));
    exp_q.push_back(TERM);
    for (int k = 0; k < ka.size(); k += P) qa.push_back(bt(ka[k], ka[k+1], ka[k+2], ka[k+3]));
    qa.push_back(TERM);
    for (int k = 0; k < kb.size(); k += P) qb.push_back(bt(kb[k], kb[k+1], kb[k+2], kb[k+3]));
    qb.push_back(TERM);
  endtask

  initial begin
    int n, acc0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #4;
    chk("rst_valid", BW'(o_valid), '0);
    chk("rst_data", o_data, '0);
    chk("rst_a_ready", BW'(a_ready), '0);
    chk("rst_b_ready", BW'(b_ready), '0);
    chk("rst_runs", BW'(runs_done), '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_a_ready", BW'(a_ready), BW'(1));
    chk("idle_b_ready", BW'(b_ready), BW'(1));

    load_t1();
    wait_drain("basic_drain", 500);
    chk("basic_runs", BW'(runs_done), BW'(1));

    exp_q.push_back(bt(32'h00010005, 32'h00010005, 32'h00010005, 32'h00010005));
    exp_q.push_back(bt(32'h00020005, 32'h00020005, 32'h00020005, 32'h00020005));
    exp_q.push_back(TERM);
    qa.push_back(bt(32'h00010005, 32'h00010005, 32'h00010005, 32'h00010005)); qa.push_back(TERM);
    qb.push_back(bt(32'h00020005, 32'h00020005, 32'h00020005, 32'h00020005)); qb.push_back(TERM);
    wait_drain("tie_drain", 500);
    chk("tie_runs", BW'(runs_done), BW'(2));

    load_t3();
    wait_drain("empty_drain", 500);
    chk("empty_runs", BW'(runs_done), BW'(4));

    rdy_pct = 30;
    load_t1();
    wait_drain("bp_drain", 2000);
    chk("bp_runs", BW'(runs_done), BW'(5));
    rdy_pct = 100;
    repeat (2) @(posedge clk);

    acc0 = acc_cnt;
    load_t1();
    n = 0;
    while (acc_cnt < acc0 + 2 && n < 500) begin @(posedge clk); n++; end
    tests++;
    if (acc_cnt < acc0 + 2) begin
      fails++;
      $display("FAIL midrun_wait: %0d beats accepted, required 2", acc_cnt - acc0);
    end
    @(posedge clk); #2;
    rst_n = 1'b0; abort = 1'b1;
    qa.delete(); qb.delete(); exp_q.delete();
    #1;
    chk("midrst_valid", BW'(o_valid), '0);
    chk("midrst_runs", BW'(runs_done), '0);
    chk("midrst_data", o_data, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; abort = 1'b0;
    repeat (2) @(posedge clk); #1;
    load_t3();
    wait_drain("postrst_drain", 500);
    chk("postrst_runs", BW'(runs_done), BW'(2));

    do_reset();
    gap_pct = 30;
    rdy_pct = 70;
    for (int r = 0; r < 100; r++) load_random_run();
    wait_drain("random_drain", 40000);
    chk("random_runs", BW'(runs_done), BW'(100));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
